serial_channel_router: RTL and testbench
========================================

# serial_channel_router

Sequential front-end for the 1-to-4 demultiplexer. It receives a serial frame, decodes a 2-bit channel address, and drives `sel` to the `demux1to4` instance. The instance routes the data bits onto the selected channel line. Per-channel deserialisers collect the routed bits into words and flag each completed word with a one-cycle valid pulse.

## Interface
- `DATA_W`, default 8: payload bits per frame; must be ≥ 2.
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `rst_n` input, 1 bit: reset, synchronous, active-low.
- `in` input, 1 bit: serial frame bit, sampled only when `in_valid` = 1.
- `in_valid` input, 1 bit: qualifies `in`; 0 stalls the FSM in its current state.
- `sel` output, 2 bits: registered channel address driven to the demux.
- `demux_out` output, 4 bits: demux output; the routed data bit during DATA, otherwise 0.
- `ch_data` output, 4×`DATA_W` bits: channel k occupies bits [k·DATA_W +: DATA_W]; holds the last good word for that channel.
- `ch_valid` output, 4 bits: one-hot, one-cycle pulse when a channel's word updates.
- `busy` output, 1 bit: 1 in any state other than IDLE.
- `frame_err` output, 1 bit: one-cycle pulse on a bad stop bit.

## Operation
- Frame layout, counted in valid beats: start (`in`=1), then address A1 and A0 (MSB first), then DATA_W data bits (MSB first), then stop (`in`=0). Total length is DATA_W+4 beats.
- FSM states and transitions:
  - IDLE→ADDR on a valid beat with `in`=1. A valid beat with `in`=0 in IDLE is ignored (line idle).
  - ADDR: two valid beats shift into `sel`; then go to DATA.
  - DATA: DATA_W valid beats. Each beat goes through the demux into channel `sel`'s shift register. A counter counts 0..DATA_W-1, then the FSM goes to STOP.
  - STOP: on a valid beat with `in`=0, copy the shift register to `ch_data[sel]`, pulse `ch_valid[sel]`, and return to IDLE.
  - STOP with `in`=1: pulse `frame_err`, leave `ch_data` unchanged, and return to IDLE. The stop bit is not reinterpreted as a start bit.
- `in_valid`=0 in any state: hold state, counter, shift registers and `sel`. Stalls may occur between any two beats and have no limit.
- Each channel has its own shift register. Only the addressed channel shifts. The other channels' `ch_data` are never disturbed.
- `demux_out` is `in` gated by (state==DATA && `in_valid`), routed by `sel`. It is combinational from the inputs and registered state.
- Reset values (when `rst_n`=0 at a clock edge):
  - State IDLE, counter 0.
  - `sel`=0, all `ch_data`=0, `ch_valid`=0.
  - `frame_err`=0, `busy`=0, shift registers 0.
- Reset mid-frame discards the partial frame. The next frame starts cleanly from IDLE.

## Timing
- `sel` is updated on the edge that samples A0. It is stable for the entire DATA and STOP phases.
- `ch_valid` and `frame_err` are registered. They assert in the cycle after the stop beat is sampled and last exactly one cycle.
- `ch_data[k]` changes on the same edge that `ch_valid[k]` rises.
- Minimum frame is DATA_W+4 cycles with `in_valid` held at 1. With DATA_W=8 this is 12 cycles.
- Back-to-back frames: the cycle after the stop beat is IDLE and may carry the next start bit. The `ch_valid` pulse from the previous frame coincides with that start beat.
- `busy` rises in the cycle after the start beat. It falls in the cycle after the stop beat.

## Structure
- The shared package holds:
  - The state enum (IDLE, ADDR, DATA, STOP).
  - `NUM_CH=4`.
  - `ADDR_W=2`.
- The `demux1to4` sub-module is instantiated once, with `.in` as the gated data bit, `.sel` as `sel`, and `.out` as `demux_out`.
- The per-channel shift registers load from `demux_out[k]`, each enabled by its own line.
- Counter width is $clog2(DATA_W).

## Test plan
- Reset, then frame 1,1,0,0xA5,0 with `in_valid`=1 → `sel`=2'b10; `ch_data[2]`=0xA5; `ch_valid`=4'b0100 for one cycle, 12 cycles after the start beat; other channels stay 0.
- Four back-to-back frames to channels 0..3 with 0x11, 0x22, 0x33, 0x44 → each `ch_valid` bit pulses once in order; the final `ch_data` holds {0x44,0x33,0x22,0x11}.
- Frame to channel 1 with random `in_valid`=0 gaps (up to 5 cycles) between beats → `ch_data[1]` is correct; `ch_valid[1]` pulses exactly once; `demux_out[1]` mirrors the data bits only on valid DATA beats.
- Frame with stop bit 1 to channel 3, payload 0xFF, preceded by a good 0x3C to channel 3 → `frame_err` pulses; `ch_data[3]` remains 0x3C; no `ch_valid`.
- `rst_n`=0 asserted during DATA of a channel-0 frame → the next cycle shows state IDLE, `busy`=0, and all `ch_data`=0; a following clean frame of 0x5A to channel 0 succeeds.
- `in`=0 with `in_valid`=1 for 20 cycles in IDLE → `busy` stays 0 and no outputs change.

Source files
------------

// File: rtl/serial_channel_router_pkg.sv
// Shared types and constants for the serial channel router: FSM states,
// channel count, address width and a channel one-hot decoder.
package serial_channel_router_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      STOP = 2'd3
   } state_t;

   localparam int NUM_CH = 4;
   localparam int ADDR_W = 2;

   function automatic logic [NUM_CH-1:0] ch_onehot(input logic [ADDR_W-1:0] addr);
      return NUM_CH'(1) << addr;
   endfunction

endpackage

// File: rtl/serial_channel_router_if.sv
// Bus bundle between a serial frame source (master) and the router (slave).
interface serial_channel_router_if
   import serial_channel_router_pkg::*;
   #(parameter int DATA_W = 8)
   ();

   logic                     in;
   logic                     in_valid;
   logic [ADDR_W-1:0]        sel;
   logic [NUM_CH-1:0]        demux_out;
   logic [NUM_CH*DATA_W-1:0] ch_data;
   logic [NUM_CH-1:0]        ch_valid;
   logic                     busy;
   logic                     frame_err;

   modport master (
      output in, in_valid,
      input  sel, demux_out, ch_data, ch_valid, busy, frame_err
   );

   modport slave (
      input  in, in_valid,
      output sel, demux_out, ch_data, ch_valid, busy, frame_err
   );

endinterface

// File: rtl/serial_channel_router_demux1to4.sv
// Combinational 1-to-4 demultiplexer: the input bit appears on the line
// picked by sel, all other lines are 0.
module demux1to4
   import serial_channel_router_pkg::*;
   (
      input  logic              in,
      input  logic [ADDR_W-1:0] sel,
      output logic [NUM_CH-1:0] out
   );

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_line
      assign out[gi] = in & (sel == ADDR_W'(gi));
   end

endmodule

// File: rtl/serial_channel_router.sv
// Serial frame receiver: start, 2-bit channel address, DATA_W data bits and a
// stop bit; data is routed through a demux into per-channel word registers.
module serial_channel_router
   import serial_channel_router_pkg::*;
   #(parameter int DATA_W = 8)
   (
      input  logic             clk,
      input  logic             rst_n,
      serial_channel_router_if.slave bus
   );

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [ADDR_W-1:0]  sel_reg, sel_next;
   logic [NUM_CH-1:0]  ch_valid_reg, ch_valid_next;
   logic               frame_err_reg, frame_err_next;
   logic [NUM_CH-1:0]  ch_load;
   logic [NUM_CH-1:0]  shift_en;
   logic [NUM_CH-1:0]  demux_out;
   logic               data_beat;
   logic               gated_in;
   logic [DATA_W-1:0]  shift_reg [NUM_CH];
   logic [DATA_W-1:0]  ch_data_reg [NUM_CH];

   // A DATA beat is the only moment a bit reaches the demux and a shifter.
   assign data_beat = (state_reg == DATA) && bus.in_valid;
   assign gated_in  = bus.in & data_beat;
   assign shift_en  = ch_onehot(sel_reg) & {NUM_CH{data_beat}};

   demux1to4 u_demux (
      .in  (gated_in),
      .sel (sel_reg),
      .out (demux_out)
   );

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      sel_next       = sel_reg;
      ch_valid_next  = '0;
      frame_err_next = 1'b0;
      ch_load        = '0;
      if (bus.in_valid) begin
         case (state_reg)
            IDLE: begin
               if (bus.in) begin
                  state_next = ADDR;
                  cnt_next   = '0;
               end
            end
            ADDR: begin
               sel_next = {sel_reg[ADDR_W-2:0], bus.in};
               if (cnt_reg == CNT_W'(1)) begin
                  state_next = DATA;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end
            DATA: begin
               if (cnt_reg == CNT_LAST) begin
                  state_next = STOP;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end
            STOP: begin
               // A high stop bit ends the frame as an error, never as a new start.
               state_next = IDLE;
               if (!bus.in) begin
                  ch_valid_next = ch_onehot(sel_reg);
                  ch_load       = ch_onehot(sel_reg);
               end else begin
                  frame_err_next = 1'b1;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         sel_reg       <= '0;
         ch_valid_reg  <= '0;
         frame_err_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         sel_reg       <= sel_next;
         ch_valid_reg  <= ch_valid_next;
         frame_err_reg <= frame_err_next;
      end
   end

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            shift_reg[gi]   <= '0;
            ch_data_reg[gi] <= '0;
         end else begin
            if (shift_en[gi]) begin
               shift_reg[gi] <= {shift_reg[gi][DATA_W-2:0], demux_out[gi]};
            end
            if (ch_load[gi]) begin
               ch_data_reg[gi] <= shift_reg[gi];
            end
         end
      end
      assign bus.ch_data[gi*DATA_W +: DATA_W] = ch_data_reg[gi];
   end

   assign bus.sel       = sel_reg;
   assign bus.demux_out = demux_out;
   assign bus.ch_valid  = ch_valid_reg;
   assign bus.frame_err = frame_err_reg;
   assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_serial_channel_router.sv
// Directed bench for serial_channel_router with DATA_W = 8.
module tb_serial_channel_router;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   serial_channel_router_if #(.DATA_W(8)) bus ();

   serial_channel_router #(.DATA_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input logic b, input logic v);
      @(negedge clk);
      bus.in       = b;
      bus.in_valid = v;
   endtask

   // Frame = start, A1, A0, D7..D0, stop; registered outputs are checked at
   // each negedge, demux_out 1 time unit after the inputs settle.
   task automatic send_frame(input logic [1:0] addr, input logic [7:0] data,
                             input logic stp, input int max_gap,
                             input logic [3:0] start_valid);
      logic [11:0] bits;
      logic [3:0]  exp_dm;
      int          g;
      bits = {1'b1, addr, data, stp};
      for (int i = 0; i < 12; i++) begin
         if (i > 0 && max_gap > 0) begin
            g = $urandom_range(max_gap, 0);
            for (int k = 0; k < g; k++) begin
               step(1'($urandom_range(1, 0)), 1'b0);
               check("gap_busy", 32'(bus.busy), 32'd1);
               check("gap_valid", 32'(bus.ch_valid), 32'd0);
               if (i >= 4) check("gap_sel", 32'(bus.sel), 32'(addr));
               #1;
               check("gap_demux", 32'(bus.demux_out), 32'd0);
            end
         end
         step(bits[11-i], 1'b1);
         if (i == 0) begin
            check("start_busy", 32'(bus.busy), 32'd0);
            check("start_valid", 32'(bus.ch_valid), 32'(start_valid));
         end else begin
            check("beat_busy", 32'(bus.busy), 32'd1);
            check("beat_valid", 32'(bus.ch_valid), 32'd0);
            check("beat_err", 32'(bus.frame_err), 32'd0);
         end
         if (i >= 3) check("beat_sel", 32'(bus.sel), 32'(addr));
         exp_dm = (i >= 3 && i <= 10) ? (4'(bits[11-i]) << addr) : 4'd0;
         #1;
         check("demux", 32'(bus.demux_out), 32'(exp_dm));
      end
      $display("frame ch=%0d data=%h stop=%0d", addr, data, stp);
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      rst_n        = 1'b0;
      bus.in       = 1'b0;
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_sel", 32'(bus.sel), 32'd0);
      check("rst_data", bus.ch_data, 32'd0);
      check("rst_valid", 32'(bus.ch_valid), 32'd0);
      check("rst_err", 32'(bus.frame_err), 32'd0);
      check("rst_demux", 32'(bus.demux_out), 32'd0);
      rst_n = 1'b1;

      // Single frame to channel 2
      send_frame(2'd2, 8'hA5, 1'b0, 0, 4'b0000);
      step(1'b0, 1'b0);
      check("t1_valid", 32'(bus.ch_valid), 32'h4);
      check("t1_data", bus.ch_data, 32'h00A50000);
      check("t1_sel", 32'(bus.sel), 32'd2);
      check("t1_busy", 32'(bus.busy), 32'd0);
      step(1'b0, 1'b0);
      check("t1_pulse", 32'(bus.ch_valid), 32'd0);

      // Back-to-back frames, each start beat coincides with the prior pulse
      send_frame(2'd0, 8'h11, 1'b0, 0, 4'b0000);
      send_frame(2'd1, 8'h22, 1'b0, 0, 4'b0001);
      send_frame(2'd2, 8'h33, 1'b0, 0, 4'b0010);
      send_frame(2'd3, 8'h44, 1'b0, 0, 4'b0100);
      step(1'b0, 1'b0);
      check("t2_valid", 32'(bus.ch_valid), 32'h8);
      check("t2_data", bus.ch_data, 32'h44332211);

      // Channel 1 with stalls between beats
      send_frame(2'd1, 8'h96, 1'b0, 5, 4'b0000);
      step(1'b0, 1'b0);
      check("t3_valid", 32'(bus.ch_valid), 32'h2);
      check("t3_data", bus.ch_data, 32'h44339611);
      step(1'b0, 1'b0);
      check("t3_pulse", 32'(bus.ch_valid), 32'd0);

      // Good 0x3C then a bad-stop 0xFF to channel 3
      send_frame(2'd3, 8'h3C, 1'b0, 0, 4'b0000);
      send_frame(2'd3, 8'hFF, 1'b1, 0, 4'b1000);
      step(1'b0, 1'b0);
      check("t4_err", 32'(bus.frame_err), 32'd1);
      check("t4_valid", 32'(bus.ch_valid), 32'd0);
      check("t4_data", bus.ch_data, 32'h3C339611);
      check("t4_busy", 32'(bus.busy), 32'd0);
      step(1'b0, 1'b0);
      check("t4_pulse", 32'(bus.frame_err), 32'd0);

      // Reset during DATA of a channel-0 frame
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      check("t5_midbusy", 32'(bus.busy), 32'd1);
      @(negedge clk);
      rst_n        = 1'b0;
      bus.in       = 1'b1;
      bus.in_valid = 1'b1;
      @(negedge clk);
      check("t5_busy", 32'(bus.busy), 32'd0);
      check("t5_data", bus.ch_data, 32'd0);
      check("t5_sel", 32'(bus.sel), 32'd0);
      check("t5_demux", 32'(bus.demux_out), 32'd0);
      rst_n        = 1'b1;
      bus.in_valid = 1'b0;
      send_frame(2'd0, 8'h5A, 1'b0, 0, 4'b0000);
      step(1'b0, 1'b0);
      check("t5_valid", 32'(bus.ch_valid), 32'h1);
      check("t5_newdata", bus.ch_data, 32'h0000005A);

      // Idle line: in=0 with in_valid=1 is ignored
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b1);
         if (i > 0) begin
            check("t6_busy", 32'(bus.busy), 32'd0);
            check("t6_valid", 32'(bus.ch_valid), 32'd0);
            check("t6_err", 32'(bus.frame_err), 32'd0);
            check("t6_data", bus.ch_data, 32'h0000005A);
         end
      end
      step(1'b0, 1'b0);
      check("t6_final_busy", 32'(bus.busy), 32'd0);
      $display("idle line 20 beats");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
